decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register and operand data width.
REQ-002 SHALL have parameter REG_NO, default 32, number of architectural registers; address width AW = $clog2(REG_NO).
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Rst  in  1  reset, asynchronous, active-low.
REQ-005 if_valid  in  1  IF/ID slot holds a valid instruction.
REQ-006 if_instr  in  32  instruction word.
REQ-007 if_pc  in  32  PC of if_instr.
REQ-008 flush  in  1  taken branch/jump from EX; kill the instruction in decode.
REQ-009 rf_read  out  1  register-file read enable.
REQ-010 rf_src1_add, rf_src2_add  out  AW  register-file read addresses.
REQ-011 rf_src1_data, rf_src2_data  in  DATA_WIDTH  register-file read data, same cycle.
REQ-012 stall  out  1  hold PC and IF/ID this cycle.
REQ-013 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal  out  1 each  registered ID/EX controls.
REQ-014 ex_pc  out  32; ex_imm  out  32; ex_rs1_data, ex_rs2_data  out  DATA_WIDTH; ex_rd, ex_rs1, ex_rs2  out  AW; ex_funct3  out  3; ex_alu_op  out  4.

Function
REQ-015 rf_read SHALL equal if_valid; rf_src1_add = if_instr[19:15], rf_src2_add = if_instr[24:20], truncated to AW bits.
REQ-016 Decode SHALL recognise opcodes R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other opcode is illegal.
REQ-017 ex_imm SHALL be the sign-extended I/S/B/U/J immediate per RV32I for the opcode type; R-type and illegal give 0.
REQ-018 ex_alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10; SUB/SRA only when funct7[5]=1 (SUB R-type only); LOAD/STORE/JAL/JALR/AUIPC ADD; BRANCH SUB; LUI PASSB.
REQ-019 ex_reg_write=1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC; ex_mem_read=1 for LOAD only; ex_mem_write=1 for STORE only; ex_branch=1 for BRANCH; ex_jump=1 for JAL/JALR; ex_alu_src_imm=1 for all except R and BRANCH.
REQ-020 Illegal opcode SHALL issue ex_valid=1, ex_illegal=1, all write/mem/branch/jump enables 0.
REQ-021 rs1 is used by R, I-ALU, LOAD, STORE, BRANCH, JALR; rs2 by R, STORE, BRANCH.
REQ-022 Load-use hazard = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
REQ-023 stall SHALL equal hazard & ~flush (combinational); a hazard stalls exactly one cycle, since the next ID/EX content is a bubble.
REQ-024 A bubble SHALL set every ex_* output to 0.
REQ-025 ID/EX update priority per posedge: flush -> bubble; hazard -> bubble; ~if_valid -> bubble; otherwise load the decoded instruction and rf data.
REQ-026 Pipeline latency SHALL be one cycle from IF/ID to ID/EX.

Reset
REQ-027 Rst=0 SHALL immediately (asynchronously) clear every ex_* register to 0; stall=0 while reset is asserted.
REQ-028 Reset asserted mid-stall SHALL discard the pending hazard; first post-reset cycle decodes normally.

Verification
REQ-029 Rst=0 with random inputs -> all ex_* = 0, stall=0; release, if_valid=0 -> outputs stay 0.
REQ-030 if_instr=0xFFD08293 (addi x5,x1,-3), rf_src1_data=10 -> next cycle ex_valid=1, ex_rd=5, ex_rs1_data=10, ex_imm=0xFFFFFFFD, ex_alu_op=0, ex_alu_src_imm=1, ex_reg_write=1.
REQ-031 0x00012303 (lw x6,0(x2)) then 0x001303B3 (add x7,x6,x1) -> stall=1 for one cycle, one bubble, then add issued with ex_rs1=6, ex_rs2=1, ex_rd=7.
REQ-032 Same load-use pair with flush=1 in the hazard cycle -> stall=0, next ex_valid=0.
REQ-033 if_instr=0xFFFFFFFF -> ex_valid=1, ex_illegal=1, ex_reg_write=ex_mem_write=ex_mem_read=0.
REQ-034 0x00322423 (sw x3,8(x4)) -> ex_imm=8, ex_mem_write=1, ex_reg_write=0, ex_alu_op=0, ex_funct3=2.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, reads the register file,
// detects load-use hazards and registers the result into the ID/EX slot.
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NO     = 32,
    localparam int AW        = $clog2(REG_NO)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [31:0]           if_pc,
    input  logic                  flush,
    output logic                  rf_read,
    output logic [AW-1:0]         rf_src1_add,
    output logic [AW-1:0]         rf_src2_add,
    input  logic [DATA_WIDTH-1:0] rf_src1_data,
    input  logic [DATA_WIDTH-1:0] rf_src2_data,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_alu_src_imm,
    output logic                  ex_illegal,
    output logic [31:0]           ex_pc,
    output logic [31:0]           ex_imm,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [AW-1:0]         ex_rd,
    output logic [AW-1:0]         ex_rs1,
    output logic [AW-1:0]         ex_rs2,
    output logic [2:0]            ex_funct3,
    output logic [3:0]            ex_alu_op
);

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src_imm;
        logic                  illegal;
        logic [31:0]           pc;
        logic [31:0]           imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [AW-1:0]         rd;
        logic [AW-1:0]         rs1;
        logic [AW-1:0]         rs2;
        logic [2:0]            funct3;
        logic [3:0]            alu_op;
    } idex_t;

    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt,
                                               input logic is_r);
        case (f3)
            3'b000:  return (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    opcode_e     opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [AW-1:0] rs1, rs2;
    logic        use_rs1, use_rs2, load_use;
    idex_t       dec, idex_d, idex_q;

    assign opcode = opcode_e'(if_instr[6:0]);
    assign rs1    = if_instr[15 +: AW];
    assign rs2    = if_instr[20 +: AW];

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc;
        dec.rs1_data = rf_src1_data;
        dec.rs2_data = rf_src2_data;
        dec.rd       = if_instr[7 +: AW];
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.funct3   = if_instr[14:12];
        case (opcode)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_from_funct(if_instr[14:12], if_instr[30], 1'b1);
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                dec.alu_op      = alu_from_funct(if_instr[14:12], if_instr[30], 1'b0);
                use_rs1         = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                use_rs1         = 1'b1;
            end
            OP_STORE: begin
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_s;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                dec.alu_op = ALU_SUB;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_JAL: begin
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_j;
            end
            OP_JALR: begin
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_i;
                use_rs1         = 1'b1;
            end
            OP_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
                dec.alu_op      = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.imm         = imm_u;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign load_use = if_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) &
                      ((use_rs1 & (rs1 == idex_q.rd)) | (use_rs2 & (rs2 == idex_q.rd)));
    assign stall    = load_use & ~flush;

    // flush, hazard and an empty slot all produce the same bubble, so one guard suffices
    always_comb begin
        idex_d = '0;
        if (if_valid && !flush && !load_use) idex_d = dec;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) idex_q <= '0;
        else      idex_q <= idex_d;
    end

    assign rf_read     = if_valid;
    assign rf_src1_add = rs1;
    assign rf_src2_add = rs2;

    assign ex_valid       = idex_q.valid;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_mem_read    = idex_q.mem_read;
    assign ex_mem_write   = idex_q.mem_write;
    assign ex_branch      = idex_q.branch;
    assign ex_jump        = idex_q.jump;
    assign ex_alu_src_imm = idex_q.alu_src_imm;
    assign ex_illegal     = idex_q.illegal;
    assign ex_pc          = idex_q.pc;
    assign ex_imm         = idex_q.imm;
    assign ex_rs1_data    = idex_q.rs1_data;
    assign ex_rs2_data    = idex_q.rs2_data;
    assign ex_rd          = idex_q.rd;
    assign ex_rs1         = idex_q.rs1;
    assign ex_rs2         = idex_q.rs2;
    assign ex_funct3      = idex_q.funct3;
    assign ex_alu_op      = idex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random instruction streams
// compared against an instruction-level model of the decode stage.
module tb_decode_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int ALU_TBL [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic          Clk = 1'b0;
    logic          Rst;
    logic          if_valid, flush, rf_read, stall;
    logic [31:0]   if_instr, if_pc;
    logic [AW-1:0] rf_src1_add, rf_src2_add;
    logic [DW-1:0] rf_src1_data, rf_src2_data;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic          ex_branch, ex_jump, ex_alu_src_imm, ex_illegal;
    logic [31:0]   ex_pc, ex_imm;
    logic [DW-1:0] ex_rs1_data, ex_rs2_data;
    logic [AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic [2:0]    ex_funct3;
    logic [3:0]    ex_alu_op;

    typedef struct packed {
        logic          valid, reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal;
        logic [31:0]   pc;
        logic [31:0]   imm;
        logic [DW-1:0] rs1_data;
        logic [DW-1:0] rs2_data;
        logic [AW-1:0] rd, rs1, rs2;
        logic [2:0]    funct3;
        logic [3:0]    alu_op;
    } exp_t;

    exp_t mq;
    int   checks = 0;
    int   errors = 0;
    logic last_stall, stall_seen;

    decode_stage #(.DATA_WIDTH(DW), .REG_NO(32)) dut (
        .Clk(Clk), .Rst(Rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .rf_read(rf_read), .rf_src1_add(rf_src1_add),
        .rf_src2_add(rf_src2_add), .rf_src1_data(rf_src1_data), .rf_src2_data(rf_src2_data),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm), .ex_illegal(ex_illegal),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_alu_op(ex_alu_op)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t dut_vec();
        return exp_t'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
                       ex_alu_src_imm, ex_illegal, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
                       ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_alu_op});
    endfunction

    // {rs1 used, rs2 used}
    function automatic logic [1:0] uses(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
            7'b0010011, 7'b0000011, 7'b1100111: return 2'b10;
            default:                            return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic r);
        int op;
        op = ALU_TBL[f3];
        if (alt && f3 == 3'd5) op = 7;
        if (alt && r && f3 == 3'd0) op = 1;
        return 4'(op);
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        int   s, hi;
        e = '0;
        e.valid = 1'b1; e.pc = pc; e.rs1_data = d1; e.rs2_data = d2;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.funct3 = ins[14:12];
        s = ins;
        case (ins[6:0])
            7'b0110011: begin
                e.reg_write = 1; e.alu_op = alu_of(ins[14:12], ins[30], 1'b1);
            end
            7'b0010011: begin
                e.reg_write = 1; e.alu_src_imm = 1; hi = s >>> 20; e.imm = hi;
                e.alu_op = alu_of(ins[14:12], ins[30], 1'b0);
            end
            7'b0000011: begin
                e.reg_write = 1; e.mem_read = 1; e.alu_src_imm = 1; hi = s >>> 20; e.imm = hi;
            end
            7'b0100011: begin
                e.mem_write = 1; e.alu_src_imm = 1; hi = s >>> 25;
                e.imm = hi * 32 + 32'(ins[11:7]);
            end
            7'b1100011: begin
                e.branch = 1; e.alu_op = 4'd1; hi = s >>> 31;
                e.imm = hi * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
            end
            7'b1101111: begin
                e.reg_write = 1; e.jump = 1; e.alu_src_imm = 1; hi = s >>> 31;
                e.imm = hi * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048
                        + 32'(ins[30:21]) * 2;
            end
            7'b1100111: begin
                e.reg_write = 1; e.jump = 1; e.alu_src_imm = 1; hi = s >>> 20; e.imm = hi;
            end
            7'b0110111: begin
                e.reg_write = 1; e.alu_src_imm = 1; e.imm = ins & 32'hFFFFF000; e.alu_op = 4'd10;
            end
            7'b0010111: begin
                e.reg_write = 1; e.alu_src_imm = 1; e.imm = ins & 32'hFFFFF000;
            end
            default: e.illegal = 1;
        endcase
        return e;
    endfunction

    // Drive one IF/ID slot for one clock and check both the combinational and registered side.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic [31:0] d1, input logic [31:0] d2);
        logic [1:0] u;
        logic       hz;
        exp_t       nx;
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
        rf_src1_data = d1; rf_src2_data = d2;
        #1;
        u  = uses(ins);
        hz = Rst && v && mq.valid && mq.mem_read && (mq.rd != 0) &&
             ((u[1] && ins[19:15] == mq.rd) || (u[0] && ins[24:20] == mq.rd));
        last_stall = hz && !fl;
        stall_seen = stall;
        chk("stall", 192'(stall), 192'(last_stall));
        chk("rf_read", 192'(rf_read), 192'(v));
        chk("rf_addr", 192'({rf_src1_add, rf_src2_add}), 192'({ins[19:15], ins[24:20]}));
        nx = (!Rst || fl || hz || !v) ? '0 : model_decode(ins, pc, d1, d2);
        @(posedge Clk);
        #1;
        mq = Rst ? nx : '0;
        chk("idex", 192'(dut_vec()), 192'(mq));
    endtask

    localparam logic [31:0] ADDI = 32'hFFD08293;
    localparam logic [31:0] LW   = 32'h00012303;
    localparam logic [31:0] ADD  = 32'h001303B3;

    initial begin
        logic [6:0]  legal [9];
        logic [31:0] ins, pc;
        logic        v, fl, hold;
        int          k;
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        mq = '0;
        Rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++)
            step(1'b1, $urandom, $urandom, 1'(($urandom)), $urandom, $urandom);
        Rst = 1'b1;
        step(1'b0, ADDI, 32'h100, 1'b0, 32'd10, 32'd3);
        step(1'b0, LW, 32'h100, 1'b0, 32'd10, 32'd3);

        step(1'b1, ADDI, 32'h100, 1'b0, 32'd10, 32'd77);
        chk("addi_valid", 192'(ex_valid), 192'(1));
        chk("addi_rd", 192'(ex_rd), 192'(5));
        chk("addi_rs1data", 192'(ex_rs1_data), 192'(10));
        chk("addi_imm", 192'(ex_imm), 192'(32'hFFFFFFFD));
        chk("addi_ctl", 192'({ex_alu_op, ex_alu_src_imm, ex_reg_write}), 192'({4'd0, 2'b11}));

        step(1'b1, LW, 32'h104, 1'b0, 32'h1000, 32'h0);
        step(1'b1, ADD, 32'h108, 1'b0, 32'd5, 32'd6);
        chk("lu_stall", 192'(stall_seen), 192'(1));
        chk("lu_bubble", 192'(ex_valid), 192'(0));
        step(1'b1, ADD, 32'h108, 1'b0, 32'd5, 32'd6);
        chk("lu_release", 192'(stall_seen), 192'(0));
        chk("lu_issue", 192'({ex_valid, ex_rs1, ex_rs2, ex_rd}), 192'({1'b1, 5'd6, 5'd1, 5'd7}));

        step(1'b1, LW, 32'h10C, 1'b0, 32'h2000, 32'h0);
        step(1'b1, ADD, 32'h110, 1'b1, 32'd5, 32'd6);
        chk("flush_stall", 192'(stall_seen), 192'(0));
        chk("flush_bubble", 192'(ex_valid), 192'(0));

        step(1'b1, 32'hFFFFFFFF, 32'h200, 1'b0, 32'd1, 32'd2);
        chk("illegal", 192'({ex_valid, ex_illegal, ex_reg_write, ex_mem_write, ex_mem_read}),
            192'(5'b11000));

        step(1'b1, 32'h00322423, 32'h204, 1'b0, 32'd4, 32'd3);
        chk("sw_imm", 192'(ex_imm), 192'(8));
        chk("sw_ctl", 192'({ex_mem_write, ex_reg_write, ex_alu_op, ex_funct3}),
            192'({2'b10, 4'd0, 3'd2}));

        step(1'b1, LW, 32'h300, 1'b0, 32'h3000, 32'h0);
        if_valid = 1'b1; if_instr = ADD; if_pc = 32'h304; flush = 1'b0;
        #1;
        chk("rst_pre_stall", 192'(stall), 192'(1));
        Rst = 1'b0;
        #1;
        chk("rst_async_clear", 192'(dut_vec()), 192'(0));
        chk("rst_stall", 192'(stall), 192'(0));
        mq = '0;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        step(1'b1, ADD, 32'h304, 1'b0, 32'd8, 32'd9);
        chk("rst_first_issue", 192'({ex_valid, ex_rd}), 192'({1'b1, 5'd7}));

        pc = 32'h1000; hold = 1'b0; ins = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                k   = $urandom_range(0, 11);
                ins = $urandom;
                if (k < 9)       ins[6:0] = legal[k];
                else if (k < 11) ins[6:0] = 7'b0000011;
                ins[11:7]  = 5'($urandom_range(0, 4));
                ins[19:15] = 5'($urandom_range(0, 4));
                ins[24:20] = 5'($urandom_range(0, 4));
                pc = pc + 32'd4;
            end
            v  = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 7) == 0);
            step(v, ins, pc, fl, $urandom, $urandom);
            hold = last_stall;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
